// File: rtl/hazard_stall_unit.sv
// Load-use / memory-wait / branch-flush stall controller with Mealy outputs.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
package hazard_stall_pkg;
  typedef logic [4:0] reg_idx_t;
  typedef enum logic [1:0] {
    from_ALU     = 2'd0,
    from_DataMem = 2'd1,
    from_PC      = 2'd2,
    from_Imm     = 2'd3
  } MReg_sel_e;
endpackage

module hazard_stall_unit
  import hazard_stall_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  reg_idx_t         id_rs1,
  input  reg_idx_t         id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  reg_idx_t         id_ex_rd,
  input  logic             id_ex_regwrite,
  input  MReg_sel_e        id_ex_MReg,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  localparam logic [2:0] REM_INIT = 3'(LOAD_USE_STALLS - 1);

  state_t     state, state_nxt, ret, ret_nxt, eff;
  logic [2:0] rem, rem_nxt;
  logic       lu, memwait, lu_ev, fl_ev;

  assign lu = id_ex_regwrite && (id_ex_MReg == from_DataMem) && (id_ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == id_ex_rd)) || (id_use_rs2 && (id_rs2 == id_ex_rd)));
  assign memwait = dmem_req && !dmem_ready;

  // When a memory wait releases, this cycle behaves exactly like the saved state.
  assign eff = (state == MEM_WAIT) ? ret : state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      ret   <= RUN;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_bubble = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    state_nxt    = state;
    ret_nxt      = ret;
    rem_nxt      = rem;
    lu_ev        = 1'b0;
    fl_ev        = 1'b0;
    if (memwait) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      state_nxt    = MEM_WAIT;
      if (state != MEM_WAIT) ret_nxt = state;
    end else if (ex_branch_taken) begin
      // The ID instruction is squashed, so any pending load-use stall is moot.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nxt    = RUN;
      rem_nxt      = '0;
      fl_ev        = 1'b1;
    end else if ((eff == LU_STALL) || lu) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      lu_ev        = 1'b1;
      if (eff == LU_STALL) begin
        if (rem <= 3'd1) begin
          state_nxt = RUN;
          rem_nxt   = '0;
        end else begin
          state_nxt = LU_STALL;
          rem_nxt   = rem - 3'd1;
        end
      end else if (LOAD_USE_STALLS > 1) begin
        state_nxt = LU_STALL;
        rem_nxt   = REM_INIT;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      state_nxt = RUN;
    end
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt <= '0;
      mem_wait_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (lu_ev)   lu_stall_cnt <= lu_stall_cnt + 1'b1;
      if (memwait) mem_wait_cnt <= mem_wait_cnt + 1'b1;
      if (fl_ev)   flush_cnt    <= flush_cnt + 1'b1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf  = lu_ev | fl_ev;
  assign lu_stall_cnt = '0;
  assign mem_wait_cnt = '0;
  assign flush_cnt    = '0;
`endif

endmodule
